// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter family: shift-mode encoding,
// FSM state type and a small helper for sizing stage counters.
package shifter_pkg;

   // Shift operation selected by the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROL = 2'b11
   } shift_mode_t;

   // Control FSM: accept in IDLE, iterate in BUSY, hold the result in DONE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } shift_state_t;

   // Width of a counter that walks 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shift stage: optionally moves the word by a given
// distance in the selected mode and reports whether any set bit fell off.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int DW    = 4
) (
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_en,
   input  logic [DW-1:0]    i_dist,
   input  shift_mode_t      i_mode,
   output logic [WIDTH-1:0] o_word,
   output logic             o_lost
);

   // Bit-by-bit shift so distances of WIDTH or more degrade cleanly to
   // all-fill without relying on out-of-range shift semantics.
   always_comb begin
      int   d;
      int   r;
      logic fill;
      d      = int'(i_dist);
      r      = d % WIDTH;
      // ASR never changes the MSB, so the current MSB is the original sign.
      fill   = (i_mode == MODE_ASR) ? i_word[WIDTH-1] : 1'b0;
      o_word = i_word;
      o_lost = 1'b0;
      if (i_en) begin
         case (i_mode)
            MODE_LSL: begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (i >= d) o_word[i] = i_word[i-d];
                  else        o_word[i] = 1'b0;
                  if (i + d >= WIDTH) o_lost = o_lost | i_word[i];
               end
            end
            MODE_LSR, MODE_ASR: begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (i + d < WIDTH) o_word[i] = i_word[i+d];
                  else               o_word[i] = fill;
                  if (i < d) o_lost = o_lost | i_word[i];
               end
            end
            default: begin
               // Rotation wraps, so only the distance modulo WIDTH matters.
               for (int i = 0; i < WIDTH; i++) begin
                  o_word[i] = i_word[(i - r + WIDTH) % WIDTH];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/iter_shifter.sv
// Iterative barrel shifter: one log2 stage per cycle, SHW cycles per request,
// valid/ready handshakes on both sides, result held until taken.
module iter_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_lost
);

   localparam int            CW   = cnt_width(SHW);
   localparam logic [CW-1:0] LAST = CW'(SHW - 1);

   shift_state_t     r_state;
   shift_state_t     w_next;
   logic [WIDTH-1:0] r_word;
   logic [SHW-1:0]   r_amt;
   shift_mode_t      r_mode;
   logic             r_lost;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_take;
   logic             w_last;
   logic [SHW-1:0]   w_dist;
   logic [WIDTH-1:0] w_stage_word;
   logic             w_stage_lost;

   assign w_accept = in_valid & in_ready;
   assign w_take   = out_valid & out_ready;
   assign w_last   = (r_cnt == LAST);
   // Stage k moves the word by 2^k when amount bit k is set.
   assign w_dist   = SHW'(1) << r_cnt;

   shift_stage #(
      .WIDTH (WIDTH),
      .DW    (SHW)
   ) u_stage (
      .i_word (r_word),
      .i_en   (r_amt[r_cnt]),
      .i_dist (w_dist),
      .i_mode (r_mode),
      .o_word (w_stage_word),
      .o_lost (w_stage_lost)
   );

   // State register; reset abandons any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: fixed SHW-cycle BUSY phase, DONE holds until taken.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_BUSY;
         ST_BUSY: if (w_last)   w_next = ST_DONE;
         ST_DONE: if (w_take)   w_next = ST_IDLE;
         default:               w_next = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded purely from state (no bypass from DONE to accept).
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
   end

   // Working word, lost flag and stage counter; operands latched only on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
         r_lost <= 1'b0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_word <= in_data;
                  r_amt  <= in_amt;
                  r_mode <= shift_mode_t'(in_mode);
                  r_lost <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            ST_BUSY: begin
               r_word <= w_stage_word;
               r_lost <= r_lost | w_stage_lost;
               r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_data = r_word;
   assign out_lost = r_lost;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter (WIDTH=11, SHW=4): vector table plus
// hand-written backpressure, reset-abort and throughput sequences.
module tb_iter_shifter;
   import shifter_pkg::*;

   localparam int WIDTH = 11;
   localparam int SHW   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_lost;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iter_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_lost  (out_lost)
   );

   typedef struct {
      logic [1:0]       mode;
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      logic [WIDTH-1:0] exp_data;
      logic             exp_lost;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] mode, input logic [WIDTH-1:0] data,
                         input logic [SHW-1:0] amt, input logic [WIDTH-1:0] exp_data,
                         input logic exp_lost);
      int guard;
      int lat;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = data;
      in_amt   = amt;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~data;
      in_amt   = ~amt;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(SHW));
      chk({tag, " data"}, 32'(out_data), 32'(exp_data));
      chk({tag, " lost"}, 32'(out_lost), 32'(exp_lost));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, " idle after take"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int first;
      int second;
      int seen;
      logic [WIDTH-1:0] tp_data;
      logic [WIDTH-1:0] tp_got;

      vecs[0]  = '{MODE_LSL, 11'b00110111011, 4'd3,  11'b10111011000, 1'b1};
      vecs[1]  = '{MODE_ASR, 11'b10000000001, 4'd2,  11'b11100000000, 1'b1};
      vecs[2]  = '{MODE_ASR, 11'b10000000001, 4'd15, 11'b11111111111, 1'b1};
      vecs[3]  = '{MODE_ROL, 11'b00000000001, 4'd12, 11'b00000000010, 1'b0};
      vecs[4]  = '{MODE_LSR, 11'b11111111111, 4'd15, 11'b00000000000, 1'b1};
      vecs[5]  = '{MODE_LSL, 11'b10110011100, 4'd0,  11'b10110011100, 1'b0};
      vecs[6]  = '{MODE_LSR, 11'b01010101010, 4'd0,  11'b01010101010, 1'b0};
      vecs[7]  = '{MODE_ASR, 11'b11000000111, 4'd0,  11'b11000000111, 1'b0};
      vecs[8]  = '{MODE_ROL, 11'b00011110000, 4'd0,  11'b00011110000, 1'b0};
      vecs[9]  = '{MODE_LSR, 11'b00000001100, 4'd2,  11'b00000000011, 1'b0};
      vecs[10] = '{MODE_LSL, 11'b00000000001, 4'd11, 11'b00000000000, 1'b1};
      vecs[11] = '{MODE_ROL, 11'b10000000000, 4'd5,  11'b00000010000, 1'b0};
      vecs[12] = '{MODE_ASR, 11'b01111111111, 4'd12, 11'b00000000000, 1'b1};
      vecs[13] = '{MODE_LSL, 11'b00000000111, 4'd9,  11'b11000000000, 1'b1};
      vecs[14] = '{MODE_ROL, 11'b00000000011, 4'd15, 11'b00000110000, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_mode   = 2'b00;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset out_lost", 32'(out_lost), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].amt,
                vecs[i].exp_data, vecs[i].exp_lost);
      end

      // Backpressure: result held 3 cycles while a second request is offered.
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = MODE_LSL;
      in_data  = 11'b00110111011;
      in_amt   = 4'd3;
      @(posedge clk);
      #1;
      in_mode  = MODE_ROL;
      in_data  = 11'b11111111111;
      in_amt   = 4'd1;
      repeat (SHW) @(posedge clk);
      #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp data c%0d", k), 32'(out_data), 32'(11'b10111011000));
         chk($sformatf("bp lost c%0d", k), 32'(out_lost), 32'd1);
         chk($sformatf("bp hs c%0d", k), {30'd0, in_ready, out_valid}, 32'b01);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("bp released", {30'd0, in_ready, out_valid}, 32'b10);

      // Reset during the second BUSY cycle discards the request.
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = MODE_ROL;
      in_data  = 11'b10110011101;
      in_amt   = 4'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort out_data", 32'(out_data), 32'd0);
      chk("abort out_lost", 32'(out_lost), 32'd0);
      seen = 0;
      out_ready = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      out_ready = 1'b0;
      chk("abort no result", 32'(seen), 32'd0);

      // Reset wins over a simultaneous handshake.
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst over accept", 32'(in_ready), 32'd1);

      // Back-to-back throughput with amount 0: one acceptance every 6 cycles.
      tp_data = 11'b01101100101;
      tp_got  = '0;
      first   = -1;
      second  = -1;
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = MODE_LSR;
      in_data   = tp_data;
      in_amt    = 4'd0;
      out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk);
         if (in_ready) begin
            if (first < 0) first = t;
            else if (second < 0) second = t;
         end
         if (out_valid && tp_got == '0) tp_got = out_data;
      end
      in_valid = 1'b0;
      chk("throughput spacing", 32'(second - first), 32'd6);
      chk("throughput data", 32'(tp_got), 32'(tp_data));
      repeat (8) @(posedge clk);
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 11, data word width in bits (>= 2).
REQ-002 Parameter SHW, default 4, shift-amount width in bits; one iteration per amount bit.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, unsigned, 0..2^SHW-1.
REQ-009 in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_lost  output  1  OR of every bit shifted out of the word; 0 for ROL.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-015 Accept when in_valid & in_ready at an edge: latch in_data, in_amt, in_mode, clear lost, stage counter to 0, go BUSY; in_data/in_amt/in_mode ignored at all other times.
REQ-016 BUSY: each cycle apply stage k (k = counter): if in_amt[k]=1, shift working word by 2^k per mode, else pass through; counter increments; after stage SHW-1 go DONE.
REQ-017 Latency: acceptance at edge N -> out_valid high after edge N+SHW; fixed, independent of amount and mode.
REQ-018 LSL/LSR fill with 0; ASR fills with latched word's MSB; ROL wraps bits, so net rotation = in_amt mod WIDTH.
REQ-019 Amount >= WIDTH: LSL/LSR -> all zeros; ASR -> all copies of sign bit; out_lost = OR of all bits not retained.
REQ-020 Amount 0: out_data = in_data, out_lost = 0, full latency still applies.
REQ-021 out_lost accumulates (OR) the bits dropped at every stage; ASR lost bits are those leaving at bit 0.
REQ-022 DONE: out_data, out_lost stable until out_valid & out_ready; on that edge go IDLE.
REQ-023 No bypass: a new request cannot be accepted in the cycle a result is taken; next acceptance earliest one cycle later.
REQ-024 in_valid held high while not IDLE SHALL have no effect.

Reset
REQ-025 rst high at an edge, in any state including mid-BUSY: state IDLE, out_valid 0, out_data 0, out_lost 0, counter 0; in-flight operation discarded, no result emitted.
REQ-026 in_ready SHALL be 1 on the first cycle after the reset edge; rst dominates any simultaneous handshake.

Structure
REQ-027 Package shifter_pkg SHALL hold the mode encoding (LSL, LSR, ASR, ROL) and FSM state typedef; shared with other shifter blocks in FloatMul.
REQ-028 One combinational sub-module shift_stage (WIDTH-parametrised: word, enable, distance 2^k, mode -> word, lost bit) is natural; iter_shifter holds FSM, counter and registers.

Verification (WIDTH=11, SHW=4)
REQ-029 LSL in=00110111011 amt=3 -> out_data=10111011000, out_lost=1, out_valid 4 cycles after acceptance.
REQ-030 ASR in=10000000001 amt=2 -> out_data=11100000000, out_lost=1; ASR amt=15 same input -> 11111111111, out_lost=1.
REQ-031 ROL in=00000000001 amt=12 -> out_data=00000000010, out_lost=0; LSR in=11111111111 amt=15 -> 00000000000, out_lost=1.
REQ-032 Backpressure: out_ready low 3 cycles in DONE -> out_data/out_lost stable, in_ready 0, second in_valid ignored; out_ready high -> IDLE next cycle, in_ready 1.
REQ-033 rst asserted on 2nd BUSY cycle -> next cycle IDLE, out_valid 0, outputs 0, no result ever emitted for that request.
REQ-034 amt=0 any mode -> out_data=in_data, out_lost=0, latency 4; back-to-back requests achieve one result per 6 cycles at best.
